// File: rtl/itch_pkg.sv
// Shared ITCH definitions: message lengths, order-book-state field layout,
// assembler state encoding and the beat-count helper.
package itch_pkg;

  // Message lengths in bytes
  localparam int OB_STATE_MSG_BYTES = 28;

  // Order-book-state message field layout (byte offset / byte length)
  localparam int OB_TS_OFF   = 0;
  localparam int OB_TS_LEN   = 4;
  localparam int OB_ID_OFF   = 4;
  localparam int OB_ID_LEN   = 4;
  localparam int OB_NAME_OFF = 8;
  localparam int OB_NAME_LEN = 20;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } asm_state_t;

  typedef struct packed {
    int beats;    // total beats the message touches
    int end_off;  // lane of the byte following the message in its final beat
  } beat_calc_t;

  // Number of beats and trailing lane for a message starting at lane off.
  function automatic beat_calc_t calc_beats(input int off, input int msg_bytes,
                                            input int bpb);
    beat_calc_t r;
    r.beats   = (off + msg_bytes + bpb - 1) / bpb;
    r.end_off = (off + msg_bytes) % bpb;
    return r;
  endfunction

endpackage

// File: rtl/itch_lane_shifter.sv
// Maps the lanes of one beat onto message byte positions: message byte k
// takes lane j when k = beat*BPB + j - off. Bytes that land outside the
// message are dropped; o_mask marks the message bytes this beat supplies.
module itch_lane_shifter #(
  parameter int DATA_W    = 64,
  parameter int MSG_BYTES = 28,
  parameter int OFF_W     = 3,
  parameter int BEAT_W    = 3
) (
  input  logic [DATA_W-1:0]      i_data,
  input  logic [BEAT_W-1:0]      i_beat,
  input  logic [OFF_W-1:0]       i_off,
  output logic [8*MSG_BYTES-1:0] o_bytes,
  output logic [MSG_BYTES-1:0]   o_mask
);

  localparam int BPB = DATA_W / 8;

  int w_base;

  assign w_base = int'(i_beat) * BPB - int'(i_off);

  // Byte-granular crossbar selected by the beat's position in the message
  always_comb begin
    o_bytes = '0;
    o_mask  = '0;
    for (int k = 0; k < MSG_BYTES; k++) begin
      for (int j = 0; j < BPB; j++) begin
        if (k - j == w_base) begin
          o_bytes[8*k +: 8] = i_data[8*j +: 8];
          o_mask[k]         = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/itch_msg_assembler.sv
// Collects one fixed-length ITCH message starting at any byte lane of a beat
// and presents it as a byte-indexed flat vector. Announces the final beat one
// cycle early together with the lane where the following message begins.
//
// Handshake: a beat transfers on any cycle with in_valid && in_ready; in_ready
// is tied high, so the upstream dispatcher never sees backpressure and
// in_valid alone qualifies start/start_off/in_data.
module itch_msg_assembler
  import itch_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MSG_BYTES = OB_STATE_MSG_BYTES,
  parameter int OFF_W     = $clog2(DATA_W / 8)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [OFF_W-1:0]       start_off,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   end_soon,
  output logic [OFF_W-1:0]       nxt_off,
  output logic                   nxt_same_beat,
  output logic                   msg_valid,
  output logic [8*MSG_BYTES-1:0] msg_data,
  output logic                   err,
  output asm_state_t             o_dbg_state
);

  localparam int BPB       = DATA_W / 8;
  localparam int MAX_BEATS = (BPB - 1 + MSG_BYTES + BPB - 1) / BPB;
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);

  asm_state_t             r_state;
  logic [OFF_W-1:0]       r_off;
  logic [OFF_W-1:0]       r_end_off;
  logic [BEAT_W-1:0]      r_beats_left;
  logic [BEAT_W-1:0]      r_beat;
  logic [8*MSG_BYTES-1:0] r_acc;
  logic [8*MSG_BYTES-1:0] r_msg_data;
  logic                   r_msg_valid;
  logic                   r_err;
  logic                   r_end_soon;
  logic                   r_nxt_same;

  logic [8*MSG_BYTES-1:0] w_cont_bytes;
  logic [MSG_BYTES-1:0]   w_cont_mask;
  logic [8*MSG_BYTES-1:0] w_start_bytes;
  logic [MSG_BYTES-1:0]   w_start_mask;
  logic [8*MSG_BYTES-1:0] w_merged;
  logic [8*MSG_BYTES-1:0] w_start_acc;
  beat_calc_t             w_calc;
  logic                   w_take_start;
  logic                   w_collect_beat;
  logic                   w_final;

  assign w_calc         = calc_beats(int'(start_off), MSG_BYTES, BPB);
  assign w_take_start   = in_valid && start;
  assign w_collect_beat = in_valid && (r_state == ST_COLLECT);
  assign w_final        = w_collect_beat && (r_beats_left == BEAT_W'(1));

  // Continuing-message view of the beat (uses the latched offset and index)
  itch_lane_shifter #(
    .DATA_W   (DATA_W),
    .MSG_BYTES(MSG_BYTES),
    .OFF_W    (OFF_W),
    .BEAT_W   (BEAT_W)
  ) u_cont_shift (
    .i_data (in_data),
    .i_beat (r_beat),
    .i_off  (r_off),
    .o_bytes(w_cont_bytes),
    .o_mask (w_cont_mask)
  );

  // New-message view of the same beat; needed separately because a start on
  // the final beat both completes the old message and opens a new one
  itch_lane_shifter #(
    .DATA_W   (DATA_W),
    .MSG_BYTES(MSG_BYTES),
    .OFF_W    (OFF_W),
    .BEAT_W   (BEAT_W)
  ) u_start_shift (
    .i_data (in_data),
    .i_beat ('0),
    .i_off  (start_off),
    .o_bytes(w_start_bytes),
    .o_mask (w_start_mask)
  );

  // Merge this beat's bytes over the accumulator; a new start begins from zero
  always_comb begin
    w_merged    = r_acc;
    w_start_acc = '0;
    for (int k = 0; k < MSG_BYTES; k++) begin
      if (w_cont_mask[k]) w_merged[8*k +: 8] = w_cont_bytes[8*k +: 8];
      if (w_start_mask[k]) w_start_acc[8*k +: 8] = w_start_bytes[8*k +: 8];
    end
  end

  // Assembly FSM; a start later in the block overrides the collect update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_off        <= '0;
      r_end_off    <= '0;
      r_beats_left <= '0;
      r_beat       <= '0;
      r_acc        <= '0;
      r_msg_data   <= '0;
      r_msg_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_end_soon   <= 1'b0;
      r_nxt_same   <= 1'b0;
    end else begin
      r_msg_valid <= 1'b0;
      r_err       <= 1'b0;
      if (w_collect_beat) begin
        if (w_final) begin
          r_msg_data  <= w_merged;
          r_msg_valid <= 1'b1;
          r_state     <= ST_IDLE;
          r_end_soon  <= 1'b0;
        end else begin
          r_acc        <= w_merged;
          r_beats_left <= r_beats_left - BEAT_W'(1);
          r_beat       <= r_beat + BEAT_W'(1);
          r_end_soon   <= (r_beats_left == BEAT_W'(2));
          if (start) r_err <= 1'b1;
        end
      end
      if (w_take_start) begin
        r_state      <= ST_COLLECT;
        r_off        <= start_off;
        r_end_off    <= OFF_W'(w_calc.end_off);
        r_beats_left <= BEAT_W'(w_calc.beats - 1);
        r_beat       <= BEAT_W'(1);
        r_acc        <= w_start_acc;
        r_end_soon   <= (w_calc.beats == 2);
        r_nxt_same   <= (w_calc.end_off != 0);
      end
    end
  end

  assign in_ready      = 1'b1;
  assign end_soon      = r_end_soon;
  assign nxt_off       = r_end_off;
  assign nxt_same_beat = r_nxt_same;
  assign msg_valid     = r_msg_valid;
  assign msg_data      = r_msg_data;
  assign err           = r_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_itch_msg_assembler.sv
// Bench for itch_msg_assembler: table-driven scenarios, hand-written corner
// sequences and randomized messages against a byte-stream reference model.
module tb_itch_msg_assembler;
  import itch_pkg::*;

  localparam int DATA_W = 64;
  localparam int MSG_B  = 28;
  localparam int BPB    = DATA_W / 8;
  localparam int MW     = 8 * MSG_B;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [2:0]        start_off = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              end_soon;
  logic [2:0]        nxt_off;
  logic              nxt_same_beat;
  logic              msg_valid;
  logic [MW-1:0]     msg_data;
  logic              err;
  asm_state_t        dbg_state;

  int n_vec = 0;
  int n_miss = 0;
  int err_seen = 0;
  int err_exp = 0;

  logic [MW-1:0] exp_q[$];
  logic [7:0]    sb[0:255];

  typedef struct {
    int off;
    int stalls;
    int exp_n;
    int exp_nxt;
    bit exp_same;
  } vec_t;

  vec_t tbl[5];

  itch_msg_assembler #(.DATA_W(DATA_W), .MSG_BYTES(MSG_B), .OFF_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_off    (start_off),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .end_soon     (end_soon),
    .nxt_off      (nxt_off),
    .nxt_same_beat(nxt_same_beat),
    .msg_valid    (msg_valid),
    .msg_data     (msg_data),
    .err          (err),
    .o_dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every msg_valid pulse must match the oldest expected message
  always @(negedge clk) begin
    if (msg_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_msg_valid: got %h expected none", msg_data);
      end else begin
        chk("msg_data", msg_data, exp_q.pop_front());
      end
    end
    if (err) err_seen++;
  end

  // Reference byte stream: messages are placed at absolute byte positions,
  // beat b carries stream bytes b*BPB .. b*BPB+BPB-1
  task automatic fill_rand();
    for (int i = 0; i < 256; i++) sb[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic place(input logic [MW-1:0] m, input int pos);
    for (int k = 0; k < MSG_B; k++) sb[pos + k] = m[8*k +: 8];
  endtask

  function automatic logic [DATA_W-1:0] get_beat(input int b);
    logic [DATA_W-1:0] d;
    for (int j = 0; j < BPB; j++) d[8*j +: 8] = sb[b * BPB + j];
    return d;
  endfunction

  function automatic logic [MW-1:0] rand_msg();
    logic [MW-1:0] m;
    for (int k = 0; k < MSG_B; k++) m[8*k +: 8] = 8'($urandom_range(0, 255));
    return m;
  endfunction

  // Driver: one accepted beat, outputs sampled 1 time unit after the edge
  task automatic send_beat(input logic st, input int off, input int b);
    start     = st;
    start_off = 3'(off);
    in_valid  = 1'b1;
    in_data   = get_beat(b);
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    start    = 1'b0;
    in_data  = {$urandom, $urandom};
    @(posedge clk);
    #1;
  endtask

  // One complete message at stream offset off, with stalls before the final beat
  task automatic run_msg(input logic [MW-1:0] m, input int off, input int stalls,
                         input int n, input int nxt, input bit same);
    fill_rand();
    place(m, off);
    exp_q.push_back(m);
    for (int b = 0; b < n; b++) begin
      if (b == n - 1) begin
        for (int s = 0; s < stalls; s++) begin
          idle_cycle();
          chk("end_soon_stall", end_soon, 1);
          chk("nxt_off_stall", nxt_off, nxt);
        end
      end
      send_beat(b == 0, off, b);
      if (b == n - 2) begin
        chk("end_soon", end_soon, 1);
        chk("nxt_off", nxt_off, nxt);
        chk("nxt_same_beat", nxt_same_beat, same);
      end else if (b < n - 2) begin
        chk("end_soon_early", end_soon, 0);
      end else begin
        chk("msg_valid_final", msg_valid, 1);
        chk("end_soon_after", end_soon, 0);
      end
    end
  endtask

  initial begin
    logic [MW-1:0] m;
    logic [MW-1:0] mb;
    logic [MW-1:0] mc;
    int off;
    int n;

    tbl[0] = '{off: 0, stalls: 0, exp_n: 4, exp_nxt: 4, exp_same: 1'b1};
    tbl[1] = '{off: 5, stalls: 2, exp_n: 5, exp_nxt: 1, exp_same: 1'b1};
    tbl[2] = '{off: 4, stalls: 0, exp_n: 4, exp_nxt: 0, exp_same: 1'b0};
    tbl[3] = '{off: 7, stalls: 1, exp_n: 5, exp_nxt: 3, exp_same: 1'b1};
    tbl[4] = '{off: 3, stalls: 0, exp_n: 4, exp_nxt: 7, exp_same: 1'b1};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_end_soon", end_soon, 0);
    chk("rst_nxt_off", nxt_off, 0);
    chk("rst_nxt_same", nxt_same_beat, 0);
    chk("rst_msg_valid", msg_valid, 0);
    chk("rst_msg_data", msg_data, 0);
    chk("rst_err", err, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    idle_cycle();

    // Beat without start in IDLE is ignored
    fill_rand();
    send_beat(1'b0, 0, 0);
    chk("idle_ignore_end_soon", end_soon, 0);
    chk("idle_ignore_state", dbg_state, ST_IDLE);
    idle_cycle();
    chk("idle_ignore_msg_valid", msg_valid, 0);

    // Table-driven scenarios; first uses the counting pattern byte k = k
    for (int t = 0; t < 5; t++) begin
      if (t == 0) for (int k = 0; k < MSG_B; k++) m[8*k +: 8] = 8'(k);
      else m = rand_msg();
      run_msg(m, tbl[t].off, tbl[t].stalls, tbl[t].exp_n, tbl[t].exp_nxt, tbl[t].exp_same);
      idle_cycle();
      chk("single_pulse", msg_valid, 0);
    end

    // Start on the final beat, then a lane-0 start on the following beat
    fill_rand();
    for (int k = 0; k < MSG_B; k++) m[8*k +: 8] = 8'(k);
    mb = rand_msg();
    mc = rand_msg();
    place(m, 0);
    place(mb, 28);
    place(mc, 56);
    exp_q.push_back(m);
    exp_q.push_back(mb);
    exp_q.push_back(mc);
    for (int b = 0; b < 11; b++) begin
      send_beat(b == 0 || b == 3 || b == 7, (b == 3) ? 4 : 0, b);
      if (b == 2) chk("rearm_end_soon_a", end_soon, 1);
      if (b == 3) begin
        chk("rearm_msg_valid_a", msg_valid, 1);
        chk("rearm_err", err, 0);
        chk("rearm_end_soon_low", end_soon, 0);
      end
      if (b == 5) begin
        chk("rearm_end_soon_b", end_soon, 1);
        chk("rearm_nxt_off_b", nxt_off, 0);
        chk("rearm_nxt_same_b", nxt_same_beat, 0);
      end
      if (b == 6) chk("rearm_msg_valid_b", msg_valid, 1);
      if (b == 10) chk("lane0_msg_valid_c", msg_valid, 1);
    end
    idle_cycle();

    // Start reasserted on beat 2: first message abandoned
    fill_rand();
    m  = rand_msg();
    mb = rand_msg();
    place(m, 2);
    place(mb, 22);
    exp_q.push_back(mb);
    err_exp++;
    for (int b = 0; b < 7; b++) begin
      send_beat(b == 0 || b == 2, (b == 0) ? 2 : 6, b);
      if (b == 2) begin
        chk("restart_err", err, 1);
        chk("restart_msg_valid", msg_valid, 0);
      end
      if (b == 3) chk("restart_err_clear", err, 0);
      if (b == 5) chk("restart_nxt_off", nxt_off, 2);
      if (b == 6) chk("restart_msg_valid", msg_valid, 1);
    end
    idle_cycle();

    // Reset on beat 2
    fill_rand();
    place(rand_msg(), 1);
    send_beat(1'b1, 1, 0);
    send_beat(1'b0, 1, 1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = get_beat(2);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mrst_end_soon", end_soon, 0);
    chk("mrst_nxt_off", nxt_off, 0);
    chk("mrst_nxt_same", nxt_same_beat, 0);
    chk("mrst_msg_valid", msg_valid, 0);
    chk("mrst_msg_data", msg_data, 0);
    chk("mrst_err", err, 0);
    chk("mrst_state", dbg_state, ST_IDLE);
    idle_cycle();
    run_msg(rand_msg(), 6, 0, 5, 2, 1'b1);
    idle_cycle();

    // Randomized messages; expected beat count and next lane from stream arithmetic
    for (int r = 0; r < 30; r++) begin
      off = $urandom_range(0, 7);
      n   = (off + MSG_B + BPB - 1) / BPB;
      repeat ($urandom_range(0, 2)) idle_cycle();
      run_msg(rand_msg(), off, $urandom_range(0, 3), n, (off + MSG_B) % BPB,
              ((off + MSG_B) % BPB) != 0);
    end

    repeat (3) idle_cycle();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("err_pulse_count", err_seen, err_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/itch_msg_assembler.md
# itch_msg_assembler

Parametrised byte-aligning assembler for fixed-length ITCH messages carried on a DATA_W-bit beat stream at arbitrary byte offsets. It collects one message that starts at a given byte lane of a beat and produces the whole message as a byte-indexed flat vector. It also reports the byte offset at which the next message begins, and raises that report one cycle before the final beat is consumed. It sits behind the message-type dispatcher, shares the broadcast beat bus with its sibling assemblers, and feeds per-type field decoders.

## Interface
- DATA_W, 64: beat width in bits; multiple of 8; BPB = DATA_W/8.
- MSG_BYTES, 28: message length in bytes; must exceed BPB, so every message spans at least 2 beats.
- OFF_W, $clog2(BPB): byte-offset width.
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- start  in  1  first beat of a message is on in_data; qualified by in_valid.
- start_off  in  OFF_W  byte lane of message byte 0 in the start beat.
- in_valid  in  1  in_data valid.
- in_data  in  DATA_W  beat; lane j = in_data[8j+:8].
- in_ready  out  1  beat accepted when in_valid && in_ready.
- end_soon  out  1  next accepted beat is the final beat of the message.
- nxt_off  out  OFF_W  byte lane of the next message's byte 0 in the final beat; valid while end_soon.
- nxt_same_beat  out  1  next message starts inside the final beat (nxt_off != 0); valid while end_soon.
- msg_valid  out  1  one-cycle pulse: msg_data holds a complete message.
- msg_data  out  8*MSG_BYTES  message byte k = msg_data[8k+:8].
- err  out  1  one-cycle pulse: start was accepted while a message was being collected.

## Operation
- States: IDLE, COLLECT.
- in_ready is 1 in both states.
- IDLE, on start && in_valid:
  - Latch off = start_off.
  - Total beats N = ceil((off+MSG_BYTES)/BPB); beats_left = N-1.
  - Compute end_off = (off+MSG_BYTES) mod BPB.
  - Write lanes off..BPB-1 into accumulator bytes 0..BPB-1-off.
  - Go to COLLECT.
- IDLE, in_valid without start: beat is ignored.
- COLLECT, each accepted beat b (b = 1..N-1):
  - Lane j maps to message byte b*BPB + j - off.
  - Bytes at index MSG_BYTES and above are discarded.
  - beats_left decrements.
- Final beat accepted (beats_left == 1):
  - Copy the accumulator, including this beat's bytes, to msg_data.
  - Pulse msg_valid the next cycle.
  - Return to IDLE.
- end_soon = (state == COLLECT && beats_left == 1). It is a level that holds through in_valid stalls.
- nxt_off = end_off.
- nxt_same_beat = (end_off != 0).
  - If end_off == 0, the next message starts at lane 0 of the following beat.
- start && in_valid in COLLECT:
  - Pulse err.
  - Discard the partial message; no msg_valid.
  - Restart collection with the new start_off from this beat.
- Start on the final beat (dispatcher re-arming the same instance):
  - The final beat completes normally: msg_valid pulses next cycle.
  - That beat is also taken as the new start; state stays COLLECT. No err.
- msg_data is stable from the msg_valid pulse until the next completion; the accumulator is separate.
- Reset:
  - Mid-operation reset aborts the message; no msg_valid.
  - State goes to IDLE.
  - msg_data, nxt_off, the accumulator and all flags clear to 0.

## Timing
- Reset values: in_ready=1, end_soon=0, nxt_off=0, nxt_same_beat=0, msg_valid=0, msg_data=0, err=0.
- Latency: msg_valid is asserted 1 cycle after the final beat is accepted.
- With no stalls, msg_valid comes N cycles after the start beat.
- end_soon rises 1 cycle after the penultimate beat is accepted. It falls 1 cycle after the final beat is accepted, unless a same-beat restart re-arms it.
- in_valid low: no state change, and end_soon/nxt_off hold.
- All outputs are registered except in_ready (constant 1).

## Structure
- itch_pkg holds:
  - message length constants: OB_STATE_MSG_BYTES = 28;
  - field byte offsets and widths for the order-book-state message: timestamp byte 0 / 4 bytes, order book ID byte 4 / 4 bytes, state name byte 8 / 20 bytes;
  - a function computing N and end_off from off and MSG_BYTES.
- Sub-module itch_lane_shifter: combinational byte-granular shift of in_data by (b*BPB - off), with a per-byte write-enable mask into the accumulator.

## Test plan
- DATA_W=64, MSG_BYTES=28, start_off=0, message bytes 0x00..0x1B, 4 back-to-back beats:
  - end_soon is high during beat 3, with nxt_off=4 and nxt_same_beat=1.
  - msg_valid pulses the cycle after beat 3; byte k = k.
- start_off=5, 5 beats, with in_valid dropped for 2 cycles before the final beat:
  - end_soon is held through the stall; nxt_off=1.
  - msg_data is correct and msg_valid arrives exactly once.
- start_off=4, 4 beats:
  - nxt_off=0, nxt_same_beat=0.
  - Next start at lane 0 of the following beat completes a second message correctly.
- start on the final beat with start_off=4 (from the first scenario):
  - Both messages complete; err stays 0.
- start reasserted on beat 2 mid-collection:
  - err pulses; no msg_valid for the first message.
  - The second message is assembled from the new offset.
- rst asserted on beat 2:
  - All outputs are 0 next cycle.
  - A subsequent full message produces correct msg_data.
